// File: rtl/ip_rr_arbiter.sv
// ip_rr_arbiter: N-channel round-robin burst arbiter.
// Grants one slave channel at a time and holds the grant for a whole burst.
// Accepted beats are forwarded with one registered cycle of latency.
// A burst ends on mstr_cmplt, or parks in WAIT_CMPLT once MAX_BURST beats have been taken.
module ip_rr_arbiter #(
  parameter int NUM_SLV   = 4,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [2*NUM_SLV-1:0]                   slv_mode,
  input  logic [NUM_SLV-1:0]                     slv_data_valid,
  input  logic [8*NUM_SLV-1:0]                   slv_proc_val,
  input  logic [DW*NUM_SLV-1:0]                  slv_data,
  output logic [NUM_SLV-1:0]                     slv_ready,
  input  logic                                   mstr_cmplt,
  input  logic                                   fifo_full,
  output logic [1:0]                             slvx_mode,
  output logic [7:0]                             slvx_proc_val,
  output logic [DW-1:0]                          slvx_data,
  output logic                                   slvx_data_valid,
  output logic [((NUM_SLV > 1) ? $clog2(NUM_SLV) : 1)-1:0] slvx_grant_id,
  output logic                                   busy
);

  localparam int                GW       = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int                CW       = $clog2(MAX_BURST + 1);
  localparam int unsigned       N        = NUM_SLV;
  localparam logic [CW-1:0]     MAX_CNT  = CW'(MAX_BURST);
  localparam logic [CW-1:0]     LAST_CNT = CW'(MAX_BURST - 1);
  localparam logic [GW-1:0]     LAST_ID  = GW'(NUM_SLV - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WAIT_CMPLT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   rr_ptr;
  logic [CW-1:0]   beat_cnt;
  logic            pick_found;
  logic [GW-1:0]   pick_id;
  int unsigned     scan_idx;
  logic            can_take;
  logic            accept;
  logic [GW-1:0]   next_ptr;

  logic [1:0]      mode_ch [NUM_SLV];
  logic [7:0]      pv_ch   [NUM_SLV];
  logic [DW-1:0]   data_ch [NUM_SLV];

  // Unpack the flat per-channel buses into indexable arrays.
  for (genvar i = 0; i < NUM_SLV; i++) begin : g_unpack
    assign mode_ch[i] = slv_mode[2*i +: 2];
    assign pv_ch[i]   = slv_proc_val[8*i +: 8];
    assign data_ch[i] = slv_data[DW*i +: DW];
  end

  // Round-robin search: first valid channel at or above rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = 32'(rr_ptr) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!pick_found && slv_data_valid[GW'(scan_idx)]) begin
        pick_found = 1'b1;
        pick_id    = GW'(scan_idx);
      end
    end
  end

  // Beat acceptance, ready generation and busy flag.
  always_comb begin
    can_take  = !fifo_full && (beat_cnt < MAX_CNT);
    accept    = (state == XFER) && can_take && slv_data_valid[slvx_grant_id];
    next_ptr  = (slvx_grant_id == LAST_ID) ? '0 : slvx_grant_id + GW'(1);
    slv_ready = '0;
    if (state == XFER && can_take) slv_ready[slvx_grant_id] = 1'b1;
    busy      = (state != IDLE);
  end

  // Next-state logic; completion takes priority over the beat limit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (pick_found) state_nxt = XFER;
      XFER: begin
        if (mstr_cmplt)                               state_nxt = IDLE;
        else if (accept && beat_cnt == LAST_CNT)      state_nxt = WAIT_CMPLT;
      end
      WAIT_CMPLT: if (mstr_cmplt) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant capture, beat forwarding, beat counting and pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr          <= '0;
      beat_cnt        <= '0;
      slvx_grant_id   <= '0;
      slvx_mode       <= '0;
      slvx_proc_val   <= '0;
      slvx_data       <= '0;
      slvx_data_valid <= 1'b0;
    end else begin
      slvx_data_valid <= accept;
      if (accept) begin
        slvx_data <= data_ch[slvx_grant_id];
        beat_cnt  <= beat_cnt + CW'(1);
      end
      if (state == IDLE && pick_found) begin
        slvx_grant_id <= pick_id;
        slvx_mode     <= mode_ch[pick_id];
        slvx_proc_val <= pv_ch[pick_id];
        beat_cnt      <= '0;
      end
      if (state != IDLE && state_nxt == IDLE) rr_ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_ip_rr_arbiter.sv
// Self-checking bench for ip_rr_arbiter: directed scenarios plus random traffic,
// all checked against a behavioural reference model of the arbitration rules.
module tb_ip_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2*N-1:0]    slv_mode = '0;
  logic [N-1:0]      slv_data_valid = '0;
  logic [8*N-1:0]    slv_proc_val = '0;
  logic [DW*N-1:0]   slv_data = '0;
  logic [N-1:0]      slv_ready;
  logic              mstr_cmplt = 1'b0;
  logic              fifo_full = 1'b0;
  logic [1:0]        slvx_mode;
  logic [7:0]        slvx_proc_val;
  logic [DW-1:0]     slvx_data;
  logic              slvx_data_valid;
  logic [1:0]        slvx_grant_id;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;
  bit auto_data = 1'b1;
  int seq [N];

  // Reference model state
  int            m_state = 0;  // 0 idle, 1 transferring, 2 waiting for completion
  int            m_ptr = 0;
  int            m_gid = 0;
  int            m_cnt = 0;
  logic [1:0]    m_mode = '0;
  logic [7:0]    m_pv = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_dv = 1'b0;

  always #5 clk = ~clk;

  ip_rr_arbiter #(.NUM_SLV(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .slv_mode(slv_mode), .slv_data_valid(slv_data_valid),
    .slv_proc_val(slv_proc_val), .slv_data(slv_data), .slv_ready(slv_ready),
    .mstr_cmplt(mstr_cmplt), .fifo_full(fifo_full), .slvx_mode(slvx_mode),
    .slvx_proc_val(slvx_proc_val), .slvx_data(slvx_data), .slvx_data_valid(slvx_data_valid),
    .slvx_grant_id(slvx_grant_id), .busy(busy)
  );

  function automatic int pick(int ptr, logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic bit m_accept();
    return (m_state == 1) && slv_data_valid[m_gid] && !fifo_full && (m_cnt < MB);
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_state == 1 && !fifo_full && m_cnt < MB) r[m_gid] = 1'b1;
    return r;
  endfunction

  // Reference model of the arbitration rules, advanced each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_ptr <= 0; m_gid <= 0; m_cnt <= 0;
      m_mode <= '0; m_pv <= '0; m_data <= '0; m_dv <= 1'b0;
    end else begin
      m_dv <= 1'b0;
      case (m_state)
        0: if (pick(m_ptr, slv_data_valid) >= 0) begin
          m_gid   <= pick(m_ptr, slv_data_valid);
          m_mode  <= slv_mode[2*pick(m_ptr, slv_data_valid) +: 2];
          m_pv    <= slv_proc_val[8*pick(m_ptr, slv_data_valid) +: 8];
          m_cnt   <= 0;
          m_state <= 1;
        end
        1: begin
          if (m_accept()) begin
            m_data      <= slv_data[DW*m_gid +: DW];
            m_dv        <= 1'b1;
            m_cnt       <= m_cnt + 1;
            seq[m_gid]  <= seq[m_gid] + 1;
          end
          if (mstr_cmplt) begin
            m_state <= 0;
            m_ptr   <= (m_gid + 1) % N;
          end else if (m_accept() && m_cnt + 1 == MB) begin
            m_state <= 2;
          end
        end
        default: if (mstr_cmplt) begin
          m_state <= 0;
          m_ptr   <= (m_gid + 1) % N;
        end
      endcase
    end
  end

  // Every-cycle scoreboard: all DUT outputs against the model, mid-cycle.
  always @(negedge clk) begin
    vectors++;
    if ({slv_ready, busy, slvx_grant_id, slvx_mode, slvx_proc_val, slvx_data, slvx_data_valid} !==
        {m_ready(), (m_state != 0), 2'(m_gid), m_mode, m_pv, m_data, m_dv}) begin
      miscompares++;
      $display("FAIL model t=%0t got rdy=%b busy=%b gid=%0d mode=%0d pv=%h data=%h dv=%b exp rdy=%b busy=%b gid=%0d mode=%0d pv=%h data=%h dv=%b",
               $time, slv_ready, busy, slvx_grant_id, slvx_mode, slvx_proc_val, slvx_data, slvx_data_valid,
               m_ready(), (m_state != 0), m_gid, m_mode, m_pv, m_data, m_dv);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_data)
      for (int c = 0; c < N; c++) slv_data[DW*c +: DW] = {seq[c][15:0], 16'($urandom)};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({slv_ready, busy, slvx_grant_id, slvx_mode, slvx_proc_val, slvx_data, slvx_data_valid} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got %h required 0",
               {slv_ready, busy, slvx_grant_id, slvx_mode, slvx_proc_val, slvx_data, slvx_data_valid});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_ch2();
    auto_data = 1'b0;
    slv_mode = 8'b0010_0000;
    slv_proc_val = 32'h005C_0000;
    slv_data[DW*2 +: DW] = 32'hA5A5_0001;
    slv_data_valid = 4'b0100;
    tick();
    vectors++;
    if (slvx_grant_id !== 2'd2 || slvx_mode !== 2'b10 || slvx_proc_val !== 8'h5C) begin
      miscompares++;
      $display("FAIL single_grant got id=%0d mode=%0d pv=%h required id=2 mode=2 pv=5c",
               slvx_grant_id, slvx_mode, slvx_proc_val);
    end
    slv_mode = 8'hFF;
    slv_proc_val = 32'hFFFF_FFFF;
    for (int b = 1; b <= 3; b++) begin
      tick();
      vectors++;
      if (slvx_data_valid !== 1'b1 || slvx_data !== 32'hA5A5_0000 + 32'(b) || slvx_mode !== 2'b10) begin
        miscompares++;
        $display("FAIL single_beat%0d got dv=%b data=%h mode=%0d required dv=1 data=%h mode=2",
                 b, slvx_data_valid, slvx_data, slvx_mode, 32'hA5A5_0000 + 32'(b));
      end
      slv_data[DW*2 +: DW] = 32'hA5A5_0001 + 32'(b);
    end
    slv_data_valid = '0;
    mstr_cmplt = 1'b1;
    tick();
    mstr_cmplt = 1'b0;
    vectors++;
    if (busy !== 1'b0 || slvx_data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end got busy=%b dv=%b required 0 0", busy, slvx_data_valid);
    end
    slv_data_valid = 4'b1001;
    tick();
    vectors++;
    if (slvx_grant_id !== 2'd3) begin
      miscompares++;
      $display("FAIL rr_ptr_after_ch2 got grant %0d required 3", slvx_grant_id);
    end
    slv_data_valid = '0;
    mstr_cmplt = 1'b1;
    tick();
    mstr_cmplt = 1'b0;
    auto_data = 1'b1;
    tick();
  endtask

  task automatic test_rr_all();
    slv_data_valid = '1;
    for (int b = 0; b < 5; b++) begin
      tick();
      vectors++;
      if (slvx_grant_id !== 2'(b % N) || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_order burst %0d got grant %0d busy %b required %0d 1", b, slvx_grant_id, busy, b % N);
      end
      tick();
      mstr_cmplt = 1'b1;
      tick();
      mstr_cmplt = 1'b0;
      vectors++;
      if (slv_ready !== '0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_gap got ready %b busy %b required 0000 0", slv_ready, busy);
      end
    end
    slv_data_valid = '0;
  endtask

  task automatic test_burst_limit();
    int n_fwd;
    int last;
    int order [3] = '{2, 3, 1};
    n_fwd = 0;
    last = seq[1] - 1;
    slv_data_valid = 4'b0010;
    tick();
    for (int c = 0; c < 6; c++) begin
      tick();
      if (slvx_data_valid) begin
        n_fwd++;
        vectors++;
        if (int'(slvx_data[31:16]) !== last + 1) begin
          miscompares++;
          $display("FAIL limit_seq got %0d required %0d", slvx_data[31:16], last + 1);
        end
        last = int'(slvx_data[31:16]);
      end
    end
    vectors++;
    if (n_fwd !== MB || slv_ready !== '0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL limit_count got beats=%0d ready=%b busy=%b required %0d 0000 1", n_fwd, slv_ready, busy, MB);
    end
    slv_data_valid = 4'b1110;
    mstr_cmplt = 1'b1;
    tick();
    mstr_cmplt = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick();
      vectors++;
      if (slvx_grant_id !== 2'(order[s])) begin
        miscompares++;
        $display("FAIL limit_order got grant %0d required %0d", slvx_grant_id, order[s]);
      end
      mstr_cmplt = 1'b1;
      tick();
      mstr_cmplt = 1'b0;
    end
    slv_data_valid = 4'b0010;
    tick();
    vectors++;
    if (slvx_grant_id !== 2'(order[2])) begin
      miscompares++;
      $display("FAIL limit_order got grant %0d required %0d", slvx_grant_id, order[2]);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      if (slvx_data_valid) begin
        n_fwd++;
        vectors++;
        if (int'(slvx_data[31:16]) !== last + 1) begin
          miscompares++;
          $display("FAIL limit_seq2 got %0d required %0d", slvx_data[31:16], last + 1);
        end
        last = int'(slvx_data[31:16]);
      end
    end
    slv_data_valid = '0;
    mstr_cmplt = 1'b1;
    tick();
    mstr_cmplt = 1'b0;
    vectors++;
    if (n_fwd !== 6) begin
      miscompares++;
      $display("FAIL limit_total got %0d beats required 6", n_fwd);
    end
  endtask

  task automatic test_fifo_full();
    int n_acc;
    int n_fwd;
    int last;
    bit exp_rdy;
    n_acc = 0;
    n_fwd = 0;
    last = seq[0] - 1;
    slv_data_valid = 4'b0001;
    tick();
    for (int c = 1; c <= 8; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      #1;
      exp_rdy = !fifo_full && (n_acc < MB);
      vectors++;
      if (slv_ready !== {3'b000, exp_rdy}) begin
        miscompares++;
        $display("FAIL fifo_ready cycle %0d got %b required %b", c, slv_ready, {3'b000, exp_rdy});
      end
      tick();
      if (exp_rdy) n_acc++;
      vectors++;
      if (slvx_data_valid !== exp_rdy) begin
        miscompares++;
        $display("FAIL fifo_dv cycle %0d got %b required %b", c, slvx_data_valid, exp_rdy);
      end
      if (slvx_data_valid) begin
        n_fwd++;
        if (int'(slvx_data[31:16]) !== last + 1) begin
          miscompares++;
          $display("FAIL fifo_seq got %0d required %0d", slvx_data[31:16], last + 1);
        end
        last = int'(slvx_data[31:16]);
      end
    end
    fifo_full = 1'b0;
    vectors++;
    if (n_fwd !== 4) begin
      miscompares++;
      $display("FAIL fifo_total got %0d required 4", n_fwd);
    end
    slv_data_valid = '0;
    mstr_cmplt = 1'b1;
    tick();
    mstr_cmplt = 1'b0;
  endtask

  task automatic test_cmplt_same_cycle();
    int s;
    slv_data_valid = 4'b0100;
    tick();
    tick();
    s = seq[2];
    mstr_cmplt = 1'b1;
    tick();
    mstr_cmplt = 1'b0;
    vectors++;
    if (slvx_data_valid !== 1'b1 || int'(slvx_data[31:16]) !== s || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cmplt_beat got dv=%b seq=%0d busy=%b required 1 %0d 0", slvx_data_valid, slvx_data[31:16], busy, s);
    end
    slv_data_valid = 4'b1100;
    #1;
    vectors++;
    if (slv_ready !== '0) begin
      miscompares++;
      $display("FAIL cmplt_idle_ready got %b required 0000", slv_ready);
    end
    tick();
    vectors++;
    if (slvx_grant_id !== 2'd3 || slv_ready[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL cmplt_next got grant %0d ready %b required grant 3 ready[2]=0", slvx_grant_id, slv_ready);
    end
    slv_data_valid = '0;
    mstr_cmplt = 1'b1;
    tick();
    mstr_cmplt = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    slv_data_valid = 4'b1000;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({slv_ready, busy, slvx_grant_id, slvx_mode, slvx_proc_val, slvx_data, slvx_data_valid} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got %h required 0",
               {slv_ready, busy, slvx_grant_id, slvx_mode, slvx_proc_val, slvx_data, slvx_data_valid});
    end
    tick();
    rst_n = 1'b1;
    slv_data_valid = 4'b1001;
    tick();
    vectors++;
    if (slvx_grant_id !== 2'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_grant got %0d busy %b required 0 1", slvx_grant_id, busy);
    end
    slv_data_valid = '0;
    mstr_cmplt = 1'b1;
    tick();
    mstr_cmplt = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      slv_data_valid = 4'($urandom);
      fifo_full      = ($urandom_range(0, 3) == 0);
      mstr_cmplt     = ($urandom_range(0, 5) == 0);
      slv_mode       = 8'($urandom);
      slv_proc_val   = $urandom;
      tick();
    end
    slv_data_valid = '0;
    fifo_full = 1'b0;
    mstr_cmplt = 1'b1;
    tick();
    mstr_cmplt = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_ch2();
    test_rr_all();
    test_burst_limit();
    test_fifo_full();
    test_cmplt_same_cycle();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
